// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling and 3-sample majority vote.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        asynchronous, active-high reset
//   rx_enable    receiver enable; low drops any frame in progress
//   rx           asynchronous serial input, idles high
//   rx_data      last correctly received byte, held until the next good frame
//   rx_valid     one-cycle pulse when rx_data is updated
//   rx_busy      high while the receiver is outside IDLE
//   frame_error  one-cycle pulse when the stop bit is sampled low
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_enable,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_error
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       s_q, s_d;
  logic [1:0]       smp_q, smp_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_error_q, frame_error_d;

  logic tick;
  logic fall;
  logic maj;
  logic decide;
  logic wrap;

  assign tick   = (cnt_q == DIV_LAST);
  assign fall   = prev_q & ~sync2_q;
  // Samples taken at s=7 and s=8 plus the live value at s=9.
  assign maj    = (smp_q[1] & smp_q[0]) | (smp_q[1] & sync2_q) | (smp_q[0] & sync2_q);
  assign decide = tick && (s_q == 4'd9);
  assign wrap   = tick && (s_q == 4'd15);

  always_comb begin
    sync1_d       = rx;
    sync2_d       = sync1_q;
    prev_d        = sync2_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    s_d           = s_q;
    smp_d         = smp_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_error_d = 1'b0;

    // The oversampling counters only run inside a frame; IDLE holds them at
    // zero so the sampling phase is anchored to the detected start edge.
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
      s_d   = 4'd0;
    end else begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) s_d = s_q + 4'd1;
    end

    if (tick && ((s_q == 4'd7) || (s_q == 4'd8))) smp_d = {smp_q[0], sync2_q};

    case (state_q)
      ST_IDLE: begin
        if (rx_enable && fall) begin
          state_d   = ST_START;
          bit_idx_d = 3'd0;
          shift_d   = 8'h00;
        end
      end
      ST_START: begin
        if (decide && maj)  state_d = ST_IDLE;
        else if (wrap) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
        end
      end
      ST_DATA: begin
        // Shifting in at the MSB makes the first (LSB) bit land in bit 0.
        if (decide) shift_d = {maj, shift_q[7:1]};
        if (wrap) begin
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (decide) begin
          if (maj) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_error_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disabling drops the frame silently.
    if (!rx_enable) begin
      state_d       = ST_IDLE;
      rx_data_d     = rx_data_q;
      rx_valid_d    = 1'b0;
      frame_error_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      prev_q        <= 1'b1;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      s_q           <= 4'd0;
      smp_q         <= 2'b11;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'h00;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      s_q           <= s_d;
      smp_q         <= smp_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = frame_error_q;
  assign rx_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx. The clock/baud parameters are
// scaled so one bit lasts 128 clocks (DIV = 8), keeping frames short.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT_CLKS = 128;

  logic       clk;
  logic       reset;
  logic       rx_enable;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_error;

  int pass_cnt;
  int total_cnt;

  uart_rx #(
    .CLK_FREQ  (1_228_800),
    .BAUD_RATE (9600),
    .OVERSAMPLE(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_enable  (rx_enable),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_busy    (rx_busy),
    .frame_error(frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running posedge count used to time events.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  int         busy_cnt = 0;
  int         width_err = 0;
  int         overlap_err = 0;
  int         busy_err = 0;
  int         data_err = 0;
  int         valid_cycle_last = 0;
  int         valid_cycle_prev = 0;
  logic [7:0] valid_data_last = 8'h00;
  logic [7:0] valid_data_prev = 8'h00;
  logic       prev_valid = 1'b0;
  logic       prev_ferr = 1'b0;
  logic       prev_busy = 1'b0;
  logic       prev_reset = 1'b1;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      valid_cycle_prev = valid_cycle_last;
      valid_cycle_last = cyc;
      valid_data_prev  = valid_data_last;
      valid_data_last  = rx_data;
    end
    if (frame_error) ferr_cnt++;
    if (rx_busy) busy_cnt++;
    if ((rx_valid && prev_valid) || (frame_error && prev_ferr)) width_err++;
    if (rx_valid && frame_error) overlap_err++;
    if ((rx_valid || frame_error) && (rx_busy || !prev_busy)) busy_err++;
    if (!reset && !prev_reset && (rx_data != prev_data) && !rx_valid) data_err++;
    prev_valid = rx_valid;
    prev_ferr  = frame_error;
    prev_busy  = rx_busy;
    prev_reset = reset;
    prev_data  = rx_data;
  end

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         bit_clks;
    bit         enable;
    bit         exp_busy;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[8];
  int   start_cycle;

  task automatic checkOutput(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drives one frame; must be called just after a falling clock edge.
  task automatic applyStimulus(input logic [7:0] data, input bit stop,
                               input int bit_clks, input bit end_level);
    rx = 1'b0;
    start_cycle = cyc;
    repeat (bit_clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (bit_clks) @(negedge clk);
    end
    rx = stop;
    repeat (bit_clks) @(negedge clk);
    rx = end_level;
  endtask

  task automatic idleBits(input int n);
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  initial begin
    int v0, f0, b0;
    int lat;
    pass_cnt  = 0;
    total_cnt = 0;

    vecs[0] = '{8'h82, 1'b1, 128, 1'b1, 1'b1, 1, 0, 8'h82};
    vecs[1] = '{8'h5A, 1'b1, 128, 1'b1, 1'b1, 1, 0, 8'h5A};
    vecs[2] = '{8'h41, 1'b0, 128, 1'b1, 1'b1, 0, 1, 8'h5A};
    vecs[3] = '{8'hFF, 1'b1, 128, 1'b0, 1'b0, 0, 0, 8'h5A};
    vecs[4] = '{8'h33, 1'b1, 124, 1'b1, 1'b1, 1, 0, 8'h33};
    vecs[5] = '{8'hC3, 1'b1, 132, 1'b1, 1'b1, 1, 0, 8'hC3};
    vecs[6] = '{8'h00, 1'b1, 128, 1'b1, 1'b1, 1, 0, 8'h00};
    vecs[7] = '{8'hFF, 1'b1, 128, 1'b1, 1'b1, 1, 0, 8'hFF};

    reset     = 1'b1;
    rx        = 1'b1;
    rx_enable = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("reset_rx_data", int'(rx_data), 0);
    checkOutput("reset_rx_valid", int'(rx_valid), 0);
    checkOutput("reset_frame_error", int'(frame_error), 0);
    checkOutput("reset_rx_busy", int'(rx_busy), 0);
    reset = 1'b0;
    idleBits(2);

    for (int i = 0; i < 8; i++) begin
      v0 = valid_cnt;
      f0 = ferr_cnt;
      b0 = busy_cnt;
      rx_enable = vecs[i].enable;
      applyStimulus(vecs[i].data, vecs[i].stop, vecs[i].bit_clks, 1'b1);
      if (i == 0) begin
        lat = valid_cycle_last - start_cycle;
        checkOutput("loopback_latency_in_range", int'(lat >= 1232 && lat <= 1238), 1);
      end
      idleBits(3);
      rx_enable = 1'b1;
      checkOutput($sformatf("vec%0d_valid_count", i), valid_cnt - v0, vecs[i].exp_valid);
      checkOutput($sformatf("vec%0d_ferr_count", i), ferr_cnt - f0, vecs[i].exp_ferr);
      checkOutput($sformatf("vec%0d_rx_data", i), int'(rx_data), int'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d_busy_seen", i), int'(busy_cnt != b0), int'(vecs[i].exp_busy));
      checkOutput($sformatf("vec%0d_busy_end", i), int'(rx_busy), 0);
    end

    // Back-to-back frames with a single stop bit in between.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    applyStimulus(8'h5A, 1'b1, BIT_CLKS, 1'b1);
    applyStimulus(8'hA5, 1'b1, BIT_CLKS, 1'b1);
    idleBits(3);
    checkOutput("b2b_valid_count", valid_cnt - v0, 2);
    checkOutput("b2b_ferr_count", ferr_cnt - f0, 0);
    checkOutput("b2b_first_data", int'(valid_data_prev), 8'h5A);
    checkOutput("b2b_second_data", int'(valid_data_last), 8'hA5);
    checkOutput("b2b_spacing", valid_cycle_last - valid_cycle_prev, 10 * BIT_CLKS);

    // Glitch shorter than half a bit: false start.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    b0 = busy_cnt;
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    idleBits(3);
    checkOutput("glitch_busy_seen", int'(busy_cnt != b0), 1);
    checkOutput("glitch_busy_short", int'((busy_cnt - b0) < 100), 1);
    checkOutput("glitch_valid_count", valid_cnt - v0, 0);
    checkOutput("glitch_ferr_count", ferr_cnt - f0, 0);
    checkOutput("glitch_busy_end", int'(rx_busy), 0);

    // Reset asserted during data bit 4 of 0x77.
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 3) ? 1'b0 : 1'b1;
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    checkOutput("midframe_busy_before_reset", int'(rx_busy), 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_rx_data", int'(rx_data), 0);
    checkOutput("midreset_rx_valid", int'(rx_valid), 0);
    checkOutput("midreset_frame_error", int'(frame_error), 0);
    checkOutput("midreset_rx_busy", int'(rx_busy), 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    idleBits(3);
    v0 = valid_cnt;
    f0 = ferr_cnt;
    applyStimulus(8'h41, 1'b1, BIT_CLKS, 1'b1);
    idleBits(3);
    checkOutput("post_reset_valid_count", valid_cnt - v0, 1);
    checkOutput("post_reset_ferr_count", ferr_cnt - f0, 0);
    checkOutput("post_reset_rx_data", int'(rx_data), 8'h41);

    // Break: all-low frame, line then held low; no retrigger.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    applyStimulus(8'h00, 1'b0, BIT_CLKS, 1'b0);
    b0 = busy_cnt;
    idleBits(3);
    checkOutput("break_ferr_count", ferr_cnt - f0, 1);
    checkOutput("break_valid_count", valid_cnt - v0, 0);
    checkOutput("break_no_retrigger", busy_cnt - b0, 0);
    checkOutput("break_rx_data", int'(rx_data), 8'h41);
    rx = 1'b1;
    idleBits(2);

    checkOutput("pulse_width_errors", width_err, 0);
    checkOutput("pulse_overlap_errors", overlap_err, 0);
    checkOutput("busy_fall_errors", busy_err, 0);
    checkOutput("data_change_errors", data_err, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
